llc_stats_collector: RTL
========================

Name: llc_stats_collector

Overview:
- Downstream consumer of the LLC: receives one result event per trace operation (command code plus hit/miss outcome) and keeps the run statistics in clocked counters.
- Statistics kept: reads, writes, hits, misses and snoops.
- On a print command (9), snapshots the counters and computes the hit ratio with a sequential restoring divider. The ratio is in milli-percent, so the 3-decimal percentage formatting moves out of real arithmetic in the testbench.
- Clear command (8) zeroes all statistics.

Parameters:
- CMDSIZE, 4: width of command code; value shared with the existing command width.
- CNT_W, 32: width of each statistic counter.
- RATIO_W, 17: quotient width; holds 0..100000.
- DIV_W, CNT_W+17: dividend width, which is also the divider iteration count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ev_valid  in  1  result event present
- ev_ready  out  1  block can accept an event
- ev_cmd  in  CMDSIZE  trace command code of the event
- ev_hit  in  1  1 = hit, 0 = miss; meaningful for cmds 0/1/2 only
- reads  out  CNT_W  live count of cmds 0 and 2
- writes  out  CNT_W  live count of cmd 1
- hits  out  CNT_W  live hit count, cmds 0/1/2
- misses  out  CNT_W  live miss count, cmds 0/1/2
- snoops  out  CNT_W  live count of cmds 3/4/5/6
- rpt_valid  out  1  one-cycle pulse: report fields valid
- rpt_hits  out  CNT_W  hits snapshot
- rpt_accesses  out  CNT_W+1  hits+misses snapshot
- rpt_ratio  out  RATIO_W  floor(hits*100000/(hits+misses)), milli-percent
- err_cmd  out  1  sticky; set when cmd 7 or 10..15 is accepted

Behaviour:
- Reset: all counters, rpt_* fields and err_cmd go to 0; rpt_valid = 0; state = IDLE; ev_ready = 1 from the first cycle after reset.
- Handshake: an event is accepted on a cycle with ev_valid & ev_ready. ev_ready = 1 only in IDLE.
- Counter updates are visible on the cycle after acceptance.
- cmd 0 or 2: reads+1; hits+1 if ev_hit, else misses+1.
- cmd 1: writes+1; hits or misses as above.
- cmd 3..6: snoops+1; ev_hit ignored.
- cmd 8: all five counters = 0. err_cmd is not cleared.
- cmd 7, 10..15: accepted; no counter change; err_cmd = 1 until reset.
- Saturation: each counter holds at 2^CNT_W-1; no wrap.
- cmd 9: snapshot rpt_hits = hits and rpt_accesses = hits+misses (CNT_W+1 bits, no overflow). The cmd-9 event itself changes no counter.
  - If rpt_accesses == 0: go to DONE with rpt_ratio = 0.
  - Else: dividend = rpt_hits*100000 (DIV_W bits), divisor = rpt_accesses; go to DIV.
- FSM states:
  - IDLE: accepts events.
  - DIV: one restoring-division step per cycle, iteration counter from DIV_W-1 down to 0; after the last step go to DONE. rpt_ratio takes the low RATIO_W bits of the quotient; the upper bits are guaranteed 0.
  - DONE: rpt_valid = 1 for exactly this cycle; then IDLE.
- Latency, with cmd 9 accepted in cycle T:
  - rpt_valid in cycle T+DIV_W+1 (T+50 at defaults).
  - rpt_valid in cycle T+1 when accesses == 0.
- Report fields hold their values until the next report completes or reset.
- Backpressure: ev_valid asserted during DIV/DONE is not accepted. The upstream side holds it; it is accepted in the first IDLE cycle.
- Reset mid-DIV: the division is aborted, no rpt_valid is produced, and the full reset values apply.

Decomposition:
- Shared package, with the rest of the cache command/trace definitions:
  - cmd_e enum: RD_DATA=0, WR_DATA=1, RD_INSTR=2, SNP_INV=3, SNP_RD=4, SNP_WR=5, SNP_RWIM=6, CLR=8, PRINT=9.
  - Constant RATIO_SCALE = 100000.
  - State enum for IDLE/DIV/DONE.
- One sub-module: seq_divider. It is a restoring divider with ports start, dividend, divisor, busy, done and quotient, parameterised on DIV_W and divisor width. The top level holds the counters, decode and FSM.

Test Plan:
1. Reset, then events (0,hit), (0,hit), (2,miss), (1,miss), then cmd 9 -> reads=3, writes=1, hits=2, misses=2; rpt_ratio=50000 and rpt_accesses=4, with rpt_valid exactly 50 cycles after cmd-9 acceptance.
2. Events (0,hit), (1,miss), (2,miss), then cmd 9 -> rpt_ratio=33333, rpt_hits=1; single-cycle rpt_valid.
3. Events (4,x), (6,x), then cmd 8, then cmd 9 -> snoops=2 before the clear; all counters 0 after; rpt_ratio=0 and rpt_valid one cycle after acceptance.
4. With CNT_W=4, 20 events of (0,hit) -> hits=15 and reads=15 (saturated); cmd 9 -> rpt_ratio=100000.
5. cmd 9 followed by ev_valid held high with (1,hit) -> ev_ready=0 for 50 cycles; writes increments only after return to IDLE. Then cmd 7 -> err_cmd=1, counters unchanged.
6. Assert reset 20 cycles into DIV -> no rpt_valid pulse; all outputs 0; ev_ready=1 on the first cycle after reset deasserts.

Source files
------------

// File: rtl/llc_stats_collector_pkg.sv
// Shared cache command/trace definitions for the LLC statistics collector.
// Holds the trace command encoding, the milli-percent ratio scale and the
// collector FSM state encoding. No ports; imported by the collector files.
package llc_stats_collector_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        RD_DATA  = 4'd0,
        WR_DATA  = 4'd1,
        RD_INSTR = 4'd2,
        SNP_INV  = 4'd3,
        SNP_RD   = 4'd4,
        SNP_WR   = 4'd5,
        SNP_RWIM = 4'd6,
        CLR      = 4'd8,
        PRINT    = 4'd9
    } cmd_e;

    // Hit ratio is reported in milli-percent: 100.000 % == 100000.
    localparam int RATIO_SCALE = 100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } state_e;

endpackage

// File: rtl/llc_stats_collector_seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   start       load dividend/divisor and begin DIV_W iterations
//   dividend    DIV_W-bit numerator
//   divisor     DVS_W-bit denominator (must be non-zero)
//   busy        iterations in progress
//   done        high during the final iteration
//   quotient    low Q_W bits of the final quotient, valid while done is high
module llc_stats_collector_seq_divider #(
    parameter int DIV_W = 49,
    parameter int DVS_W = 33,
    parameter int Q_W   = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int ITER_W = $clog2(DIV_W);

    logic [DIV_W-1:0]  quo;
    logic [DVS_W-1:0]  rem;
    logic [DVS_W-1:0]  dvs;
    logic [ITER_W-1:0] iter;
    logic [DVS_W:0]    shifted;
    logic              ge;
    logic [DIV_W-1:0]  quo_next;

    // The dividend shifts out of quo's MSB while quotient bits shift in at
    // the LSB, so one register serves both roles. The remainder is always
    // below the divisor, so one extra bit is enough for the trial compare.
    always_comb begin
        shifted  = {rem, quo[DIV_W-1]};
        ge       = (shifted >= {1'b0, dvs});
        quo_next = {quo[DIV_W-2:0], ge};
    end

    assign done     = busy && (iter == '0);
    assign quotient = quo_next[Q_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            iter <= '0;
            quo  <= '0;
            rem  <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            iter <= ITER_W'(DIV_W - 1);
            quo  <= dividend;
            rem  <= '0;
            dvs  <= divisor;
        end else if (busy) begin
            quo  <= quo_next;
            rem  <= ge ? DVS_W'(shifted - {1'b0, dvs}) : shifted[DVS_W-1:0];
            iter <= iter - ITER_W'(1);
            if (iter == '0) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/llc_stats_collector.sv
// LLC run-statistics collector. Counts result events per trace command and,
// on a print command, reports hits, accesses and the hit ratio (milli-percent)
// computed by a sequential divider.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   ev_valid/ev_ready     event handshake (ready only while idle)
//   ev_cmd, ev_hit        command code and hit/miss outcome
//   reads..snoops         live saturating statistic counters
//   rpt_valid             one-cycle pulse when report fields are updated
//   rpt_hits/accesses     report snapshot, rpt_ratio = hits*100000/accesses
//   err_cmd               sticky flag for undefined commands
module llc_stats_collector
    import llc_stats_collector_pkg::*;
#(
    parameter int CMDSIZE = CMD_W,
    parameter int CNT_W   = 32,
    parameter int RATIO_W = 17,
    parameter int DIV_W   = CNT_W + 17
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ev_valid,
    output logic               ev_ready,
    input  logic [CMDSIZE-1:0] ev_cmd,
    input  logic               ev_hit,
    output logic [CNT_W-1:0]   reads,
    output logic [CNT_W-1:0]   writes,
    output logic [CNT_W-1:0]   hits,
    output logic [CNT_W-1:0]   misses,
    output logic [CNT_W-1:0]   snoops,
    output logic               rpt_valid,
    output logic [CNT_W-1:0]   rpt_hits,
    output logic [CNT_W:0]     rpt_accesses,
    output logic [RATIO_W-1:0] rpt_ratio,
    output logic               err_cmd
);

    state_e             state, state_next;
    cmd_e               cmd;
    logic               accept;
    logic               is_print;
    logic               div_start;
    logic               div_busy;
    logic               div_done;
    logic [RATIO_W-1:0] div_quo;
    logic [CNT_W:0]     accesses;
    logic [DIV_W-1:0]   dividend;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign cmd       = cmd_e'(ev_cmd);
    assign accept    = ev_valid && ev_ready;
    assign is_print  = accept && (cmd == PRINT);
    assign accesses  = {1'b0, hits} + {1'b0, misses};
    assign dividend  = DIV_W'(hits) * DIV_W'(RATIO_SCALE);
    assign div_start = is_print && (accesses != '0);

    llc_stats_collector_seq_divider #(
        .DIV_W (DIV_W),
        .DVS_W (CNT_W + 1),
        .Q_W   (RATIO_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (accesses),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (is_print) begin
                    state_next = (accesses == '0) ? ST_DONE : ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_next = ST_DONE;
                end else if (!div_busy) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ev_ready  = (state == ST_IDLE);
        rpt_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reads   <= '0;
            writes  <= '0;
            hits    <= '0;
            misses  <= '0;
            snoops  <= '0;
            err_cmd <= 1'b0;
        end else if (accept) begin
            case (cmd)
                RD_DATA, RD_INSTR, WR_DATA: begin
                    if (cmd == WR_DATA) begin
                        writes <= sat_inc(writes);
                    end else begin
                        reads <= sat_inc(reads);
                    end
                    if (ev_hit) begin
                        hits <= sat_inc(hits);
                    end else begin
                        misses <= sat_inc(misses);
                    end
                end
                SNP_INV, SNP_RD, SNP_WR, SNP_RWIM: snoops <= sat_inc(snoops);
                CLR: begin
                    reads  <= '0;
                    writes <= '0;
                    hits   <= '0;
                    misses <= '0;
                    snoops <= '0;
                end
                PRINT: ;
                default: err_cmd <= 1'b1;
            endcase
        end
    end

    // No event is accepted between the print command and the end of the
    // division, so the live counters still equal the snapshot when the
    // report is published; fields only change when a report completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_hits     <= '0;
            rpt_accesses <= '0;
            rpt_ratio    <= '0;
        end else if ((state == ST_DIV) && div_done) begin
            rpt_hits     <= hits;
            rpt_accesses <= accesses;
            rpt_ratio    <= div_quo;
        end else if (is_print && (accesses == '0)) begin
            rpt_hits     <= hits;
            rpt_accesses <= accesses;
            rpt_ratio    <= '0;
        end
    end

endmodule
